// File: rtl/tag_ram_arbiter.sv
// rtl/tag_ram_arbiter.sv - Round-robin data/instruction arbiter for a tag RAM with bulk-clear engine
module tag_ram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  localparam int BE = DATA_WIDTH / 8,
  localparam int LB = $clog2(BE),
  localparam int WA = ADDR_WIDTH - LB
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  d_req_i,
  output logic                  d_gnt_o,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic                  d_we_i,
  input  logic [BE-1:0]         d_be_i,
  input  logic                  d_wdata_i,
  output logic                  d_rvalid_o,
  output logic [BE-1:0]         d_rdata_o,
  input  logic                  i_req_i,
  output logic                  i_gnt_o,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_rvalid_o,
  output logic [BE-1:0]         i_rdata_o,
  input  logic                  clr_req_i,
  input  logic [WA-1:0]         clr_start_i,
  input  logic [WA-1:0]         clr_end_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [BE-1:0]         ram_be_o,
  output logic                  ram_wdata_o,
  input  logic [BE-1:0]         ram_rdata_i
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          prio_i_q, prio_i_d;
  logic [WA-1:0] ptr_q, ptr_d;
  logic [WA-1:0] end_q, end_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          i_rvalid_q, i_rvalid_d;
  logic          done_q, done_d;
  logic          empty_done;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= IDLE;
      prio_i_q   <= 1'b0;
      ptr_q      <= '0;
      end_q      <= '0;
      d_rvalid_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_i_q   <= prio_i_d;
      ptr_q      <= ptr_d;
      end_q      <= end_d;
      d_rvalid_q <= d_rvalid_d;
      i_rvalid_q <= i_rvalid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_i_d    = prio_i_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    done_d      = 1'b0;
    empty_done  = 1'b0;
    d_gnt_o     = 1'b0;
    i_gnt_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          // prio_i_q set means the data port won last, so instruction wins a tie
          if (d_req_i && (!i_req_i || !prio_i_q)) begin
            d_gnt_o     = 1'b1;
            ram_en_o    = 1'b1;
            ram_we_o    = d_we_i;
            ram_addr_o  = d_addr_i;
            ram_be_o    = d_be_i;
            ram_wdata_o = d_wdata_i;
            prio_i_d    = 1'b1;
          end else if (i_req_i) begin
            i_gnt_o    = 1'b1;
            ram_en_o   = 1'b1;
            ram_addr_o = i_addr_i;
            prio_i_d   = 1'b0;
          end
          if (clr_req_i) begin
            ptr_d   = clr_start_i;
            end_d   = clr_end_i;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          // During a valid sweep ptr never passes end, so end < ptr only for an empty range
          if (end_q < ptr_q) begin
            empty_done = 1'b1;
            state_d    = IDLE;
          end else begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = {ptr_q, {LB{1'b0}}};
            ram_be_o    = '1;
            ram_wdata_o = 1'b0;
            if (ptr_q == end_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ptr_d = ptr_q + {{(WA-1){1'b0}}, 1'b1};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    d_rvalid_d = d_gnt_o;
    i_rvalid_d = i_gnt_o;
  end

  assign d_rvalid_o = d_rvalid_q && !rst_i;
  assign i_rvalid_o = i_rvalid_q && !rst_i;
  assign d_rdata_o  = ram_rdata_i;
  assign i_rdata_o  = ram_rdata_i;
  assign clr_busy_o = (state_q == CLEAR) && !rst_i;
  assign clr_done_o = (done_q || empty_done) && !rst_i;

endmodule

// File: tb/tb_tag_ram_arbiter.sv
// tb/tb_tag_ram_arbiter.sv - Self-checking bench for tag_ram_arbiter: vector table, corner sequences, random vs model
module tb_tag_ram_arbiter;

  logic        clk;
  logic        rst_i;
  logic        d_req_i, d_gnt_o, d_we_i, d_wdata_i, d_rvalid_o;
  logic [15:0] d_addr_i;
  logic [3:0]  d_be_i, d_rdata_o;
  logic        i_req_i, i_gnt_o, i_rvalid_o;
  logic [15:0] i_addr_i;
  logic [3:0]  i_rdata_o;
  logic        clr_req_i, clr_busy_o, clr_done_o;
  logic [13:0] clr_start_i, clr_end_i;
  logic        ram_en_o, ram_we_o, ram_wdata_o;
  logic [15:0] ram_addr_o;
  logic [3:0]  ram_be_o, ram_rdata_i;

  tag_ram_arbiter dut (
    .clk(clk), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .clr_req_i(clr_req_i), .clr_start_i(clr_start_i), .clr_end_i(clr_end_i),
    .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag RAM behaviour: byte-masked writes, one-cycle read latency
  logic [3:0] mem [0:16383];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o)
        mem[ram_addr_o[15:2]] <= (mem[ram_addr_o[15:2]] & ~ram_be_o) | (ram_be_o & {4{ram_wdata_o}});
      else
        ram_rdata_i <= mem[ram_addr_o[15:2]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending clear words kept as a queue, memory as an array
  logic [3:0] ref_mem [0:16383];
  int   m_clr[$];
  bit   m_busy, m_done_next, m_last_d;
  bit   m_pend_d, m_pend_i, m_pend_rd;
  logic [3:0] m_pend_val;

  task automatic model_cycle();
    bit eg_d = 0, eg_i = 0, e_en = 0, e_we = 0, e_wd = 0, e_done = 0, e_busy = 0, nd = 0;
    logic [15:0] e_addr = '0;
    logic [3:0]  e_be = '0, rd_val = '0;
    int w;
    if (rst_i) begin
      chk("rst d_gnt", d_gnt_o, 0);     chk("rst i_gnt", i_gnt_o, 0);
      chk("rst d_rvalid", d_rvalid_o, 0); chk("rst i_rvalid", i_rvalid_o, 0);
      chk("rst busy", clr_busy_o, 0);   chk("rst done", clr_done_o, 0);
      chk("rst ram_en", ram_en_o, 0);   chk("rst ram_we", ram_we_o, 0);
      m_busy = 0; m_clr.delete(); m_done_next = 0; m_last_d = 0;
      m_pend_d = 0; m_pend_i = 0; m_pend_rd = 0;
      return;
    end
    chk("d_rvalid", d_rvalid_o, m_pend_d);
    chk("i_rvalid", i_rvalid_o, m_pend_i);
    if (m_pend_rd && m_pend_d) chk("d_rdata", d_rdata_o, m_pend_val);
    if (m_pend_rd && m_pend_i) chk("i_rdata", i_rdata_o, m_pend_val);
    if (m_busy) begin
      e_busy = 1;
      if (m_clr.size() == 0) begin
        e_done = 1; m_busy = 0;
      end else begin
        w = m_clr.pop_front();
        e_en = 1; e_we = 1; e_addr = 16'(w * 4); e_be = 4'hf; e_wd = 0;
        ref_mem[w] = 4'h0;
        if (m_clr.size() == 0) begin m_busy = 0; nd = 1; end
      end
    end else begin
      e_done = m_done_next;
      if (d_req_i && (!i_req_i || !m_last_d)) eg_d = 1;
      else if (i_req_i) eg_i = 1;
      if (eg_d) begin
        e_en = 1; e_we = d_we_i; e_addr = d_addr_i; e_be = d_be_i; e_wd = d_wdata_i; m_last_d = 1;
        if (d_we_i) ref_mem[d_addr_i[15:2]] = (ref_mem[d_addr_i[15:2]] & ~d_be_i) | (d_be_i & {4{d_wdata_i}});
        else rd_val = ref_mem[d_addr_i[15:2]];
      end
      if (eg_i) begin
        e_en = 1; e_addr = i_addr_i; m_last_d = 0; rd_val = ref_mem[i_addr_i[15:2]];
      end
      if (clr_req_i) begin
        m_busy = 1;
        for (int k = int'(clr_start_i); k <= int'(clr_end_i); k++) m_clr.push_back(k);
      end
    end
    chk("d_gnt", d_gnt_o, eg_d);  chk("i_gnt", i_gnt_o, eg_i);
    chk("busy", clr_busy_o, e_busy); chk("done", clr_done_o, e_done);
    chk("ram_en", ram_en_o, e_en);
    if (e_en) begin
      chk("ram_we", ram_we_o, e_we); chk("ram_addr", ram_addr_o, e_addr);
      if (e_we) begin chk("ram_be", ram_be_o, e_be); chk("ram_wdata", ram_wdata_o, e_wd); end
    end
    m_done_next = nd;
    m_pend_d = eg_d; m_pend_i = eg_i;
    m_pend_rd = (eg_d && !d_we_i) || eg_i;
    m_pend_val = rd_val;
  endtask

  task automatic idle_in();
    rst_i = 0; d_req_i = 0; d_we_i = 0; d_be_i = 0; d_wdata_i = 0; d_addr_i = 0;
    i_req_i = 0; i_addr_i = 0; clr_req_i = 0; clr_start_i = 0; clr_end_i = 0;
  endtask

  task automatic tick();
    #2;
    model_cycle();
  endtask

  typedef struct {
    logic rst, dreq, ireq, dwe; logic [3:0] dbe; logic dwd; logic [15:0] daddr, iaddr;
    logic egd, egi, erd, eri, een, ewe; logic [15:0] eaddr; logic crd; logic [3:0] erdata;
  } vec_t;
  vec_t tbl [10];

  int busy_cnt, wr_cnt, done_cnt, done_seen, bad_gnt, gnt_at_done;

  initial begin
    for (int k = 0; k < 16384; k++) begin mem[k] = 4'h0; ref_mem[k] = 4'h0; end
    ram_rdata_i = 4'h0;
    idle_in();
    rst_i = 1;

    //            rst dq iq we be dwd daddr  iaddr  gd gi rd ri en we eaddr crd erd
    tbl[0] = '{1, 1, 1, 0, 0, 0, 16'h0,  16'h0,  0, 0, 0, 0, 0, 0, 16'h0,  0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 16'h0,  16'h0,  0, 0, 0, 0, 0, 0, 16'h0,  0, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 0, 16'h8,  16'hC,  1, 0, 0, 0, 1, 0, 16'h8,  0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0, 16'h8,  16'hC,  0, 1, 1, 0, 1, 0, 16'hC,  0, 0};
    tbl[4] = '{0, 1, 1, 0, 0, 0, 16'h8,  16'hC,  1, 0, 0, 1, 1, 0, 16'h8,  0, 0};
    tbl[5] = '{0, 1, 1, 0, 0, 0, 16'h8,  16'hC,  0, 1, 1, 0, 1, 0, 16'hC,  0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 16'h0,  16'h0,  0, 0, 0, 1, 0, 0, 16'h0,  0, 0};
    tbl[7] = '{0, 1, 0, 1, 5, 1, 16'h10, 16'h0,  1, 0, 0, 0, 1, 1, 16'h10, 0, 0};
    tbl[8] = '{0, 0, 1, 0, 0, 0, 16'h0,  16'h10, 0, 1, 1, 0, 1, 0, 16'h10, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 16'h0,  16'h0,  0, 0, 0, 1, 0, 0, 16'h0,  1, 5};

    foreach (tbl[n]) begin
      @(negedge clk);
      idle_in();
      rst_i = tbl[n].rst; d_req_i = tbl[n].dreq; i_req_i = tbl[n].ireq; d_we_i = tbl[n].dwe;
      d_be_i = tbl[n].dbe; d_wdata_i = tbl[n].dwd; d_addr_i = tbl[n].daddr; i_addr_i = tbl[n].iaddr;
      tick();
      chk($sformatf("vec%0d d_gnt", n), d_gnt_o, tbl[n].egd);
      chk($sformatf("vec%0d i_gnt", n), i_gnt_o, tbl[n].egi);
      chk($sformatf("vec%0d d_rvalid", n), d_rvalid_o, tbl[n].erd);
      chk($sformatf("vec%0d i_rvalid", n), i_rvalid_o, tbl[n].eri);
      chk($sformatf("vec%0d ram_en", n), ram_en_o, tbl[n].een);
      if (tbl[n].een) begin
        chk($sformatf("vec%0d ram_we", n), ram_we_o, tbl[n].ewe);
        chk($sformatf("vec%0d ram_addr", n), ram_addr_o, tbl[n].eaddr);
      end
      if (tbl[n].crd) chk($sformatf("vec%0d rdata", n), tbl[n].eri ? i_rdata_o : d_rdata_o, tbl[n].erdata);
    end

    // Clear 4..7 with a data request waiting behind it
    @(negedge clk); idle_in(); clr_req_i = 1; clr_start_i = 4; clr_end_i = 7; tick();
    busy_cnt = 0; done_seen = 0; bad_gnt = 0; gnt_at_done = 0;
    for (int c = 0; c < 10 && !done_seen; c++) begin
      @(negedge clk); idle_in(); d_req_i = 1; d_addr_i = 16'h40; tick();
      if (clr_busy_o) begin
        chk("clr4 addr", ram_addr_o, 16'h10 + 16'(4 * busy_cnt));
        busy_cnt++;
        if (d_gnt_o) bad_gnt++;
      end
      if (clr_done_o) begin done_seen = 1; gnt_at_done = d_gnt_o; end
    end
    chk("clr4 busy cycles", busy_cnt, 4);
    chk("clr4 done seen", done_seen, 1);
    chk("clr4 gnt during busy", bad_gnt, 0);
    chk("clr4 gnt at done", gnt_at_done, 1);
    @(negedge clk); idle_in(); i_req_i = 1; i_addr_i = 16'h10; tick();
    @(negedge clk); idle_in(); tick();
    chk("read after clear", i_rdata_o, 0);

    // Empty range 9..3, then a second request during the busy cycle
    @(negedge clk); idle_in(); clr_req_i = 1; clr_start_i = 9; clr_end_i = 3; tick();
    @(negedge clk); idle_in(); clr_req_i = 1; clr_start_i = 0; clr_end_i = 1; tick();
    chk("empty done", clr_done_o, 1);
    chk("empty no write", ram_en_o, 0);
    @(negedge clk); idle_in(); tick();
    chk("empty ignored req busy", clr_busy_o, 0);

    // Top-of-range clear must stop at the last word without wrapping
    @(negedge clk); idle_in(); clr_req_i = 1; clr_start_i = 14'd16381; clr_end_i = 14'd16383; tick();
    wr_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_in(); tick();
      if (ram_en_o && ram_we_o) wr_cnt++;
      if (clr_done_o) done_cnt++;
    end
    chk("top clear writes", wr_cnt, 3);
    chk("top clear done", done_cnt, 1);

    // Response outstanding when reset hits is dropped
    @(negedge clk); idle_in(); d_req_i = 1; d_addr_i = 16'h20; tick();
    @(negedge clk); idle_in(); rst_i = 1; tick();
    chk("rst drops rvalid", d_rvalid_o, 0);

    // Reset on the second cycle of a 0..15 clear
    @(negedge clk); idle_in(); clr_req_i = 1; clr_start_i = 0; clr_end_i = 15; tick();
    @(negedge clk); idle_in(); tick();
    @(negedge clk); idle_in(); rst_i = 1; tick();
    chk("abort busy", clr_busy_o, 0);
    wr_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_in(); tick();
      if (ram_en_o) wr_cnt++;
      if (clr_done_o) done_cnt++;
    end
    chk("abort writes", wr_cnt, 0);
    chk("abort done", done_cnt, 0);

    // Random traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); idle_in();
      rst_i     = ($urandom_range(0, 59) == 0);
      d_req_i   = $urandom_range(0, 1);
      i_req_i   = $urandom_range(0, 1);
      d_we_i    = $urandom_range(0, 1);
      d_be_i    = 4'($urandom_range(0, 15));
      d_wdata_i = $urandom_range(0, 1);
      d_addr_i  = 16'($urandom_range(0, 127));
      i_addr_i  = 16'($urandom_range(0, 127));
      clr_req_i = ($urandom_range(0, 19) == 0);
      clr_start_i = 14'($urandom_range(0, 31));
      clr_end_i   = 14'($urandom_range(0, 31));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
